// File: rtl/step_clock_ctrl_if.sv
// Bundle of key inputs, rate/breakpoint configuration and stepping outputs.
// No timing of its own; the controller registers every output.
// No backpressure: keys and configuration are level inputs, cpu_ce is a strobe.
interface step_clock_ctrl_if #(
  parameter int DIV_W  = 18,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
);
  logic              step_n;
  logic              mode_n;
  logic [DIV_W-1:0]  period;
  logic [CNT_W-1:0]  burst_len;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ce;
  logic [1:0]        mode;
  logic              halted;
  logic              busy;

  // Board/stimulus side: drives keys and configuration, observes the strobe.
  modport master (
    output step_n, mode_n, period, burst_len, bp_en, bp_addr, cpu_addr,
    input  cpu_ce, mode, halted, busy
  );

  // Controller side.
  modport slave (
    input  step_n, mode_n, period, burst_len, bp_en, bp_addr, cpu_addr,
    output cpu_ce, mode, halted, busy
  );
endinterface

// File: rtl/step_clock_ctrl.sv
// CPU stepping controller: manual step, free-run and burst, emitting a one-cycle cpu_ce.
// Latency: key edge -> press event 2+DEBOUNCE cycles, press -> cpu_ce 1 cycle; all outputs registered.
// No backpressure: pulses are strobes; presses that arrive while they cannot act are dropped.
module step_clock_ctrl #(
  parameter int DIV_W    = 18,
  parameter int CNT_W    = 8,
  parameter int ADDR_W   = 16,
  parameter int DEBOUNCE = 50000
) (
  input logic           clk,
  input logic           rst_n,
  step_clock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    BURST  = 2'd2
  } mode_t;

  localparam int DB_CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE - 1);

  // Key conditioning, index 0 = step, index 1 = mode.
  logic [1:0]            key_raw;
  logic [1:0]            sync1_q, sync2_q, db_q, press_q;
  logic [1:0][DB_CW-1:0] db_cnt_q;

  assign key_raw = {bus.mode_n, bus.step_n};

  // Synchronise, then accept a new level only after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      db_q     <= 2'b11;
      press_q  <= 2'b00;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_cnt_q[i] <= '0;
            db_q[i]     <= sync2_q[i];
            press_q[i]  <= ~sync2_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic step_press, mode_press;
  assign step_press = press_q[0];
  assign mode_press = press_q[1];

  // Stepping state.
  mode_t            mode_q;
  logic [DIV_W-1:0] div_q, per_q;
  logic [CNT_W-1:0] bcnt_q;
  logic             busy_q, halted_q, ce_q, skip_q;
  logic             due, bp_hit;

  // per_q holds the interval in force, so a new period lands at the next terminal count.
  assign due    = (div_q == per_q);
  assign bp_hit = bus.bp_en && !skip_q &&
                  (ADDR_W'(bus.cpu_addr) == ADDR_W'(bus.bp_addr));

  // Mode sequencing, rate divider, burst counting and breakpoint stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MANUAL;
      div_q    <= '0;
      per_q    <= '0;
      bcnt_q   <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ce_q     <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      ce_q <= 1'b0;
      if (mode_press) begin
        // Mode key wins over a simultaneous step press.
        case (mode_q)
          MANUAL:  mode_q <= AUTO;
          AUTO:    mode_q <= BURST;
          default: mode_q <= MANUAL;
        endcase
        div_q    <= '0;
        per_q    <= bus.period;
        bcnt_q   <= '0;
        busy_q   <= 1'b0;
        halted_q <= 1'b0;
        skip_q   <= 1'b1;
      end else begin
        case (mode_q)
          MANUAL: begin
            if (step_press) begin
              ce_q     <= 1'b1;
              halted_q <= 1'b0;
            end
          end
          AUTO: begin
            if (due) begin
              div_q <= '0;
              per_q <= bus.period;
              if (bp_hit) begin
                halted_q <= 1'b1;
                mode_q   <= MANUAL;
              end else begin
                ce_q   <= 1'b1;
                skip_q <= 1'b0;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          BURST: begin
            if (!busy_q) begin
              if (step_press && (bus.burst_len != '0)) begin
                busy_q <= 1'b1;
                per_q  <= bus.period;
                // The press cycle counts as divider count 0, so period 0 pulses at once.
                if (bus.period == '0) begin
                  ce_q   <= 1'b1;
                  skip_q <= 1'b0;
                  div_q  <= '0;
                  bcnt_q <= bus.burst_len - 1'b1;
                end else begin
                  skip_q <= 1'b1;
                  div_q  <= DIV_W'(1);
                  bcnt_q <= bus.burst_len;
                end
              end
            end else if (bcnt_q == '0) begin
              busy_q <= 1'b0;
            end else if (due) begin
              div_q <= '0;
              per_q <= bus.period;
              if (bp_hit) begin
                halted_q <= 1'b1;
                mode_q   <= MANUAL;
                busy_q   <= 1'b0;
                bcnt_q   <= '0;
              end else begin
                ce_q   <= 1'b1;
                skip_q <= 1'b0;
                bcnt_q <= bcnt_q - 1'b1;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          default: mode_q <= MANUAL;
        endcase
      end
    end
  end

  assign bus.cpu_ce = ce_q;
  assign bus.mode   = mode_q;
  assign bus.halted = halted_q;
  assign bus.busy   = busy_q;

endmodule
